// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter that shares the register-file write port among NUM_REQ write-back
// sources, with a registered write stage and a pending-write scoreboard for hazard detection.
module regfile_wb_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      reserve_valid,
  input  logic [ADDR_W-1:0]         reserve_addr,
  input  logic [ADDR_W-1:0]         rs1_addr,
  input  logic [ADDR_W-1:0]         rs2_addr,
  output logic                      rf_we,
  output logic [ADDR_W-1:0]         rf_waddr,
  output logic [DATA_W-1:0]         rf_wdata,
  output logic [(2**ADDR_W)-1:0]    pending,
  output logic                      stall
);

  localparam int unsigned NR    = NUM_REQ;
  localparam int          PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int          NREG  = 2**ADDR_W;

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [NREG-1:0]   pending_q, pending_d;

  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic [PTR_W-1:0]   cand;
  logic               found;
  logic               xfer;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_data;

  // Rotating priority scan starting at rr_ptr; first valid requester wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int unsigned k = 0; k < NR; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % NR);
      if (!found && req_valid[cand]) begin
        found       = 1'b1;
        grant_idx   = cand;
        grant[cand] = 1'b1;
      end
    end
    if (reset) begin
      grant = '0;
    end
  end

  assign xfer     = |grant;
  assign sel_addr = req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_data = req_data[grant_idx*DATA_W +: DATA_W];

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    pending_d  = pending_q;
    if (xfer) begin
      rr_ptr_d = (32'(grant_idx) == NR - 1) ? '0 : grant_idx + 1'b1;
      pending_d[sel_addr] = 1'b0;
      if (sel_addr != '0) begin
        rf_we_d    = 1'b1;
        rf_waddr_d = sel_addr;
        rf_wdata_d = sel_data;
      end
    end
    // Applied after the clear so a same-cycle reservation keeps the bit set.
    if (reserve_valid && reserve_addr != '0) begin
      pending_d[reserve_addr] = 1'b1;
    end
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
      pending_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
      pending_q  <= pending_d;
    end
  end

  assign req_ready = grant;
  assign rf_we     = rf_we_q;
  assign rf_waddr  = rf_waddr_q;
  assign rf_wdata  = rf_wdata_q;
  assign pending   = pending_q;
  assign stall     = pending_q[rs1_addr] | pending_q[rs2_addr];

endmodule
